// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider: one radix-2 restoring step per cycle,
// with a fixed-latency zero-divisor path and pipeline annul/stall handshake.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        annul,
    output logic [63:0] result,
    output logic        div_ready,
    output logic        div_stall
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_DIVZERO = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] xraw_q, xraw_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [63:0] result_q, result_d;

    logic [31:0] x_mag, y_mag;
    logic [33:0] diff;
    logic [63:0] acc_step;
    logic [31:0] quo_fix, rem_fix;

    // Negating 0x80000000 yields itself, which is the correct unsigned magnitude.
    assign x_mag = (div_signed && x[31]) ? (32'd0 - x) : x;
    assign y_mag = (div_signed && y[31]) ? (32'd0 - y) : y;

    // acc holds {partial remainder, dividend/quotient}; the shifted-out top bit is
    // kept so the trial subtraction is 33 bits wide.
    assign diff     = {1'b0, acc_q[63:31]} - {2'b00, dvsr_q};
    assign acc_step = diff[33] ? {acc_q[62:0], 1'b0}
                               : {diff[31:0], acc_q[30:0], 1'b1};

    assign quo_fix = negq_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    assign rem_fix = negr_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvsr_d   = dvsr_q;
        xraw_d   = xraw_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (div_start && !annul) begin
                    acc_d   = {32'd0, x_mag};
                    dvsr_d  = y_mag;
                    xraw_d  = x;
                    negq_d  = div_signed && (x[31] ^ y[31]);
                    negr_d  = div_signed && x[31];
                    cnt_d   = '0;
                    state_d = (y == 32'd0) ? S_DIVZERO : S_RUN;
                end
            end
            S_RUN: begin
                // Counts 0..31 each perform a step; the cycle at count 32 registers
                // the sign-fixed result, giving the 33-cycle RUN dwell.
                if (cnt_q == 6'd32) begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = S_DONE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DIVZERO: begin
                if (cnt_q == 6'd1) begin
                    result_d = {xraw_q, 32'hFFFF_FFFF};
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (annul) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvsr_q   <= '0;
            xraw_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvsr_q   <= dvsr_d;
            xraw_q   <= xraw_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign result    = result_q;
    assign div_ready = (state_q == S_DONE);
    assign div_stall = (resetn && state_q == S_IDLE && div_start && !annul)
                     || (state_q == S_RUN) || (state_q == S_DIVZERO);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result/latency/stall,
// a negedge monitor pops and compares on every div_ready.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn, div_start, div_signed, annul;
    logic [31:0] x, y;
    logic [63:0] result;
    logic        div_ready, div_stall;

    typedef struct {
        logic [63:0] res;
        int unsigned cyc;
        int unsigned stall;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned cyc = 0;
    int unsigned stall_run = 0;
    int          total = 0;
    int          bad = 0;

    div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .div_start (div_start),
        .div_signed(div_signed),
        .x         (x),
        .y         (y),
        .annul     (annul),
        .result    (result),
        .div_ready (div_ready),
        .div_stall (div_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: every div_ready pops one expectation.
    always @(negedge clk) begin
        if (resetn && div_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready got=1 want=0 cyc=%0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("stall_cycles", 64'(stall_run), 64'(e.stall));
            end
            stall_run = 0;
        end else if (div_stall) begin
            stall_run++;
        end else begin
            stall_run = 0;
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=pending want=done");
            sb.delete();
        end
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input int poke);
        exp_t n;
        @(posedge clk); #1;
        div_start = 1'b1; div_signed = sgn; x = a; y = b;
        n.res   = res;
        n.cyc   = cyc + ((b == 32'd0) ? 3 : 34);
        n.stall = (b == 32'd0) ? 3 : 34;
        sb.push_back(n);
        @(posedge clk); #1;
        div_start = 1'b0; x = $urandom; y = $urandom; div_signed = 1'($urandom);
        if (poke > 0) begin
            repeat (poke) @(posedge clk);
            #1; div_start = 1'b1; x = 32'd50; y = 32'd5;
            @(posedge clk); #1; div_start = 1'b0;
        end
        wait_empty();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; div_start = 1'b1; div_signed = 1'b0; annul = 1'b0;
        x = 32'd10; y = 32'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 64'h0);
        chk("reset_ready", 64'(div_ready), 64'h0);
        chk("reset_stall", 64'(div_stall), 64'h0);
        @(posedge clk); #1;
        resetn = 1'b1; div_start = 1'b0;

        issue(1'b0, 32'd100,        32'd7,        {32'd2, 32'd14}, 0);
        issue(1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        issue(1'b1, 32'd7,          32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 0);
        issue(1'b1, 32'h12345678,   32'd0,        {32'h12345678, 32'hFFFFFFFF}, 0);
        issue(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0, 32'h80000000}, 0);
        issue(1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'd0}, 0);
        issue(1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0, 32'hFFFFFFFF}, 0);
        issue(1'b0, 32'd5,          32'd10,       {32'd5, 32'd0}, 0);
        issue(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 0);
        issue(1'b1, 32'hFFFFFFF9,   32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}, 0);
        issue(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, {32'd0, 32'd1}, 0);
        // start pulses while busy must not launch a second operation
        issue(1'b0, 32'd1000,       32'd3,        {32'd1, 32'd333}, 5);
        repeat (40) @(posedge clk);

        // annul at RUN cycle 10
        @(posedge clk); #1;
        div_start = 1'b1; div_signed = 1'b0; x = 32'd999; y = 32'd4;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1; annul = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("annul_stall", 64'(div_stall), 64'h0);
        #1; annul = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("annul_result_hold", result, {32'd1, 32'd333});
        issue(1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 0);

        // annul coincident with start in IDLE
        @(posedge clk); #1;
        div_start = 1'b1; annul = 1'b1; x = 32'd9; y = 32'd3;
        @(negedge clk);
        chk("annul_start_stall", 64'(div_stall), 64'h0);
        @(posedge clk); #1;
        div_start = 1'b0; annul = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("annul_start_result", result, {32'd0, 32'd9});

        // reset at RUN cycle 20 with div_start held
        @(posedge clk); #1;
        div_start = 1'b1; div_signed = 1'b0; x = 32'd500; y = 32'd3;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (19) @(posedge clk);
        #1; resetn = 1'b0; div_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_result", result, 64'h0);
        chk("midrst_ready", 64'(div_ready), 64'h0);
        chk("midrst_stall", 64'(div_stall), 64'h0);
        @(posedge clk); #1;
        resetn = 1'b1; div_start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("midrst_result_hold", result, 64'h0);
        issue(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
